interp_rx_loader: RTL and testbench

// - Inbound end of the interpreter link: receives bytes from the host interpreter,

---
 rtl/interp_rx_loader.sv | 227 ++++++++++++++++++++++
 tb/tb_interp_rx_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/interp_rx_loader.sv
// Inbound interpreter link: syncs the host byte strobe, packs bytes into R-lane vectors, writes them to data_mem.
// Latency: MemWriteL asserts 1 cycle after the strobe of the last lane; ack toggles on the cycle a byte is consumed.
// Backpressure: a byte arriving while a write or done cycle is in progress is held in a one-entry pending register.
// Optional trailing XOR checksum when RX_LOADER_CHECKSUM_EN is defined.
module interp_rx_loader #(
  parameter int             I         = 32,
  parameter int             N         = 8,
  parameter int             R         = 6,
  parameter logic [I-1:0]   BASE_ADDR = '0,
  parameter int             ADDR_STEP = 1,
  parameter logic [7:0]     SYNC_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_clk,
  input  logic [7:0]            in_data,
  output logic                  ack,
  output logic                  MemWriteL,
  output logic [I-1:0]          AddressL,
  output logic [R-1:0][N-1:0]   WriteDataL,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int LW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHK, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync2_q, sync3_q;
  logic                   pend_vld_q, pend_vld_d;
  logic [7:0]             pend_dat_q, pend_dat_d;
  logic [8:0]             cnt_q, cnt_d;
  logic [8:0]             vec_idx_q, vec_idx_d;
  logic [LW-1:0]          lane_idx_q, lane_idx_d;
  logic [R-1:0][N-1:0]    lane_q, lane_d;
  logic                   ack_q, ack_d;
  logic                   we_q, we_d;
  logic [I-1:0]           addr_q, addr_d;
  logic [R-1:0][N-1:0]    wdata_q, wdata_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
`ifdef RX_LOADER_CHECKSUM_EN
  logic [7:0]             xor_q, xor_d;
`endif

  logic       byte_stb;
  logic       hold;
  logic       byte_vld;
  logic [7:0] byte_dat;

  // Rising edge of the synchronised host strobe; WRITE and DONE cannot consume a byte.
  assign byte_stb = sync2_q & ~sync3_q;
  assign hold     = (state_q == S_WRITE) || (state_q == S_DONE);
  assign byte_vld = ~hold & (pend_vld_q | byte_stb);
  assign byte_dat = pend_vld_q ? pend_dat_q : in_data;

  assign ack        = ack_q;
  assign MemWriteL  = we_q;
  assign AddressL   = addr_q;
  assign WriteDataL = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_dat_q <= '0;
      cnt_q      <= '0;
      vec_idx_q  <= '0;
      lane_idx_q <= '0;
      lane_q     <= '0;
      ack_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef RX_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= in_clk;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      pend_vld_q <= pend_vld_d;
      pend_dat_q <= pend_dat_d;
      cnt_q      <= cnt_d;
      vec_idx_q  <= vec_idx_d;
      lane_idx_q <= lane_idx_d;
      lane_q     <= lane_d;
      ack_q      <= ack_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef RX_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  // Pending slot: park a strobe that lands while the FSM cannot take it, release it on the next consuming cycle.
  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_dat_d = pend_dat_q;
    if (hold) begin
      if (byte_stb) begin
        pend_vld_d = 1'b1;
        pend_dat_d = in_data;
      end
    end else if (pend_vld_q) begin
      pend_vld_d = byte_stb;
      pend_dat_d = in_data;
    end
  end

  // Frame FSM: header, length, lane packing, write issue and frame completion.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vec_idx_d  = vec_idx_q;
    lane_idx_d = lane_idx_q;
    lane_d     = lane_q;
    ack_d      = ack_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
`ifdef RX_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (byte_vld && (byte_dat == SYNC_BYTE)) begin
          ack_d   = ~ack_q;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (byte_vld) begin
          ack_d      = ~ack_q;
          cnt_d      = (byte_dat == 8'd0) ? 9'd256 : {1'b0, byte_dat};
          vec_idx_d  = '0;
          lane_idx_d = '0;
`ifdef RX_LOADER_CHECKSUM_EN
          xor_d      = byte_dat;
`endif
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (byte_vld) begin
          ack_d              = ~ack_q;
          lane_d[lane_idx_q] = N'(byte_dat);
`ifdef RX_LOADER_CHECKSUM_EN
          xor_d              = xor_q ^ byte_dat;
`endif
          if (lane_idx_q == LW'(R - 1)) begin
            we_d       = 1'b1;
            addr_d     = BASE_ADDR + I'(vec_idx_q) * I'(ADDR_STEP);
            wdata_d    = lane_d;
            lane_idx_d = '0;
            state_d    = S_WRITE;
          end else begin
            lane_idx_d = lane_idx_q + LW'(1);
          end
        end
      end
      S_WRITE: begin
        vec_idx_d  = vec_idx_q + 9'd1;
        lane_idx_d = '0;
        if ((vec_idx_q + 9'd1) == cnt_q) begin
`ifdef RX_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
      S_CHK: begin
`ifdef RX_LOADER_CHECKSUM_EN
        if (byte_vld) begin
          ack_d  = ~ack_q;
          busy_d = 1'b0;
          if (byte_dat == xor_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_interp_rx_loader.sv
module tb_interp_rx_loader;

`ifdef RX_LOADER_CHECKSUM_EN
  localparam int CSB = 1;
`else
  localparam int CSB = 0;
`endif

  logic        clk;
  logic        reset;
  logic        in_clk;
  logic [7:0]  in_data;
  logic        ack;
  logic        MemWriteL;
  logic [31:0] AddressL;
  logic [47:0] WriteDataL;
  logic        busy;
  logic        done;
  logic        err;

  interp_rx_loader dut (
    .clk(clk), .reset(reset), .in_clk(in_clk), .in_data(in_data),
    .ack(ack), .MemWriteL(MemWriteL), .AddressL(AddressL), .WriteDataL(WriteDataL),
    .busy(busy), .done(done), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int wr_n = 0, done_n = 0, ack_n = 0;
  logic ack_prev = 1'b0;
  logic [31:0] wr_addr [4];
  logic [47:0] wr_dat [4];
  int          wr_cyc [4];
  logic [31:0] last_addr;
  logic [47:0] last_dat;
  logic [7:0]  fq [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (MemWriteL === 1'b1) begin
      if (wr_n < 4) begin
        wr_addr[wr_n] = AddressL;
        wr_dat[wr_n]  = WriteDataL;
        wr_cyc[wr_n]  = cyc;
      end
      last_addr = AddressL;
      last_dat  = WriteDataL;
      wr_n++;
    end
    if (done === 1'b1) done_n++;
    if (ack !== ack_prev) ack_n++;
    ack_prev = ack;
  end

  task automatic clr_mon();
    @(posedge clk);
    wr_n = 0; done_n = 0; ack_n = 0; ack_prev = ack;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
    @(negedge clk);
    in_data = b;
    in_clk = 1'b1;
    last_rise_cyc = cyc;
    repeat (hi) @(negedge clk);
    in_clk = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic send_q(input int hi, input int lo);
    foreach (fq[k]) send_byte(fq[k], hi, lo);
    fq.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0; in_clk = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b want 0", ack); end
    n_cmp++; if (MemWriteL !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", MemWriteL); end
    n_cmp++; if (AddressL !== 32'h0) begin n_bad++; $display("FAIL reset_addr got %h want 0", AddressL); end
    n_cmp++; if (WriteDataL !== 48'h0) begin n_bad++; $display("FAIL reset_wdata got %h want 0", WriteDataL); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    reset = 1'b1;
    clr_mon();
    send_byte(8'h00, 3, 3);
    send_byte(8'h5A, 3, 3);
    repeat (6) @(negedge clk);
    n_cmp++; if (ack_n !== 0) begin n_bad++; $display("FAIL idle_ack toggles got %0d want 0", ack_n); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b want 0", busy); end
    n_cmp++; if (wr_n !== 0) begin n_bad++; $display("FAIL idle_writes got %0d want 0", wr_n); end
  endtask

  task automatic run_single(input string tag, input logic [7:0] cs);
    int rise66;
    clr_mon();
    send_byte(8'hA5, 3, 3);
    send_byte(8'h01, 3, 3);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy_mid got %b want 1", tag, busy); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL %s err_after_hdr got %b want 0", tag, err); end
    for (int k = 1; k <= 6; k++) send_byte(8'(k * 8'h11), 3, 3);
    rise66 = last_rise_cyc;
    if (CSB != 0) send_byte(cs, 3, 3);
    repeat (10) @(negedge clk);
    n_cmp++; if (wr_n !== 1) begin n_bad++; $display("FAIL %s writes got %0d want 1", tag, wr_n); end
    n_cmp++; if (wr_addr[0] !== 32'h0) begin n_bad++; $display("FAIL %s addr got %h want 0", tag, wr_addr[0]); end
    n_cmp++; if (wr_dat[0] !== 48'h665544332211) begin n_bad++; $display("FAIL %s wdata got %h want 665544332211", tag, wr_dat[0]); end
    n_cmp++; if (wr_cyc[0] - rise66 !== 3) begin n_bad++; $display("FAIL %s latency got %0d want 3", tag, wr_cyc[0] - rise66); end
    n_cmp++; if (WriteDataL !== 48'h665544332211) begin n_bad++; $display("FAIL %s wdata_hold got %h want 665544332211", tag, WriteDataL); end
  endtask

  task automatic test_single_frame();
    run_single("single", 8'h76);
    n_cmp++; if (done_n !== 1) begin n_bad++; $display("FAIL single done_pulses got %0d want 1", done_n); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single busy_end got %b want 0", busy); end
    n_cmp++; if (ack_n !== 8 + CSB) begin n_bad++; $display("FAIL single ack_toggles got %0d want %0d", ack_n, 8 + CSB); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL single err got %b want 0", err); end
  endtask

  task automatic test_two_vectors();
    clr_mon();
    fq = '{8'hA5, 8'h02, 8'h01, 8'hA5, 8'h03, 8'h04, 8'h05, 8'h06,
           8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    if (CSB != 0) fq.push_back(8'hA9);
    send_q(3, 3);
    repeat (10) @(negedge clk);
    n_cmp++; if (wr_n !== 2) begin n_bad++; $display("FAIL two writes got %0d want 2", wr_n); end
    n_cmp++; if (wr_addr[0] !== 32'h0 || wr_addr[1] !== 32'h1) begin n_bad++; $display("FAIL two addrs got %h,%h want 0,1", wr_addr[0], wr_addr[1]); end
    n_cmp++; if (wr_dat[0] !== 48'h06050403A501) begin n_bad++; $display("FAIL two vec0 got %h want 06050403a501", wr_dat[0]); end
    n_cmp++; if (wr_dat[1] !== 48'h0C0B0A090807) begin n_bad++; $display("FAIL two vec1 got %h want 0c0b0a090807", wr_dat[1]); end
    n_cmp++; if (done_n !== 1 || busy !== 1'b0) begin n_bad++; $display("FAIL two done/busy got %0d/%b want 1/0", done_n, busy); end
  endtask

  task automatic test_back_to_back();
    clr_mon();
    fq = '{8'hA5, 8'h02, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
           8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
    if (CSB != 0) fq.push_back(8'h02);
    send_q(2, 2);
    repeat (10) @(negedge clk);
    n_cmp++; if (wr_n !== 2) begin n_bad++; $display("FAIL b2b writes got %0d want 2", wr_n); end
    n_cmp++; if (wr_dat[0] !== 48'h262524232221) begin n_bad++; $display("FAIL b2b vec0 got %h want 262524232221", wr_dat[0]); end
    n_cmp++; if (wr_dat[1] !== 48'h363534333231) begin n_bad++; $display("FAIL b2b vec1 got %h want 363534333231", wr_dat[1]); end
    n_cmp++; if (ack_n !== 14 + CSB) begin n_bad++; $display("FAIL b2b ack_toggles got %0d want %0d", ack_n, 14 + CSB); end
    n_cmp++; if (done_n !== 1) begin n_bad++; $display("FAIL b2b done_pulses got %0d want 1", done_n); end
  endtask

  task automatic test_reset_mid_frame();
    clr_mon();
    fq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
    send_q(3, 3);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid busy got %b want 0", busy); end
    n_cmp++; if (wr_n !== 0) begin n_bad++; $display("FAIL rstmid writes got %0d want 0", wr_n); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    run_single("after_rst", 8'h76);
    n_cmp++; if (done_n !== 1) begin n_bad++; $display("FAIL after_rst done_pulses got %0d want 1", done_n); end
  endtask

  task automatic test_len_256();
    logic [7:0] cs;
    logic [7:0] b;
    clr_mon();
    cs = 8'h00;
    send_byte(8'hA5, 2, 2);
    send_byte(8'h00, 2, 2);
    for (int k = 0; k < 1536; k++) begin
      b = 8'(k);
      cs = cs ^ b;
      send_byte(b, 2, 2);
    end
    if (CSB != 0) send_byte(cs, 2, 2);
    repeat (10) @(negedge clk);
    n_cmp++; if (wr_n !== 256) begin n_bad++; $display("FAIL len256 writes got %0d want 256", wr_n); end
    n_cmp++; if (wr_addr[1] !== 32'h1 || wr_dat[1] !== 48'h0B0A09080706) begin n_bad++; $display("FAIL len256 vec1 got %h@%h want 0b0a09080706@1", wr_dat[1], wr_addr[1]); end
    n_cmp++; if (last_addr !== 32'd255) begin n_bad++; $display("FAIL len256 last_addr got %h want ff", last_addr); end
    n_cmp++; if (last_dat !== 48'hFFFEFDFCFBFA) begin n_bad++; $display("FAIL len256 last_vec got %h want fffefdfcfbfa", last_dat); end
    n_cmp++; if (done_n !== 1 || busy !== 1'b0) begin n_bad++; $display("FAIL len256 done/busy got %0d/%b want 1/0", done_n, busy); end
  endtask

`ifdef RX_LOADER_CHECKSUM_EN
  task automatic test_checksum_err();
    run_single("badcs", 8'h00);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL badcs err got %b want 1", err); end
    n_cmp++; if (done_n !== 0) begin n_bad++; $display("FAIL badcs done_pulses got %0d want 0", done_n); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL badcs busy got %b want 0", busy); end
    run_single("recover", 8'h76);
    n_cmp++; if (done_n !== 1 || err !== 1'b0) begin n_bad++; $display("FAIL recover done/err got %0d/%b want 1/0", done_n, err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_two_vectors();
    test_back_to_back();
    test_reset_mid_frame();
    test_len_256();
`ifdef RX_LOADER_CHECKSUM_EN
    test_checksum_err();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
